// File: rtl/wb_pkg.sv
// Shared types for the Wishbone classic master: command/response records and FSM states.
package wb_pkg;

    localparam int WB_AW = 16;
    localparam int WB_DW = 16;

    typedef struct packed {
        logic             we;
        logic [WB_AW-1:0] adr;
        logic [WB_DW-1:0] dat;
    } wb_cmd_t;

    typedef struct packed {
        logic             we;
        logic [WB_DW-1:0] dat;
        logic             err;
    } wb_rsp_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUS  = 2'd1,
        RESP = 2'd2
    } wb_mstate_t;

endpackage

// File: rtl/wb_cmd_fifo.sv
// Command FIFO: DEPTH x wb_cmd_t, registered count, head entry visible on rdata (no fall-through).
module wb_cmd_fifo
    import wb_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic    clk,
    input  logic    rst_n,
    input  logic    push,
    input  wb_cmd_t wdata,
    input  logic    pop,
    output wb_cmd_t rdata,
    output logic    full,
    output logic    empty
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [PW-1:0] PTR_ONE = PW'(1);
    localparam logic [CW-1:0] CNT_ONE = CW'(1);
    localparam logic [CW-1:0] CNT_MAX = CW'(DEPTH);

    wb_cmd_t       mem_r [DEPTH];
    logic [PW-1:0] wr_ptr_r;
    logic [PW-1:0] rd_ptr_r;
    logic [CW-1:0] count_r;
    logic          do_push_s;
    logic          do_pop_s;

    assign full      = (count_r == CNT_MAX);
    assign empty     = (count_r == {CW{1'b0}});
    assign do_push_s = push && !full;
    assign do_pop_s  = pop && !empty;
    assign rdata     = mem_r[rd_ptr_r];

    // Storage array; contents need no reset because count gates every read.
    always_ff @(posedge clk) begin
        if (do_push_s) begin
            mem_r[wr_ptr_r] <= wdata;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_r <= {PW{1'b0}};
            rd_ptr_r <= {PW{1'b0}};
            count_r  <= {CW{1'b0}};
        end else begin
            if (do_push_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_ONE;
            end
            if (do_pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_ONE;
            end
            case ({do_push_s, do_pop_s})
                2'b10:   count_r <= count_r + CNT_ONE;
                2'b01:   count_r <= count_r - CNT_ONE;
                default: count_r <= count_r;
            endcase
        end
    end

endmodule

// File: rtl/wb_master_standard.sv
// Wishbone classic master: FIFO-buffered commands, one standard cycle and one response each.
// Optional bus timeout enabled by defining WB_MASTER_TIMEOUT_EN.
module wb_master_standard
    import wb_pkg::*;
#(
    parameter int AW      = WB_AW,
    parameter int DW      = WB_DW,
    parameter int DEPTH   = 4,
    parameter int TIMEOUT = 16
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          cmd_valid,
    output logic          cmd_ready,
    input  logic          cmd_we,
    input  logic [AW-1:0] cmd_adr,
    input  logic [DW-1:0] cmd_dat,
    output logic          rsp_valid,
    input  logic          rsp_ready,
    output logic          rsp_we,
    output logic [DW-1:0] rsp_dat,
    output logic          rsp_err,
    output logic          busy,
    output logic          wb_cyc_o,
    output logic          wb_stb_o,
    output logic          wb_we_o,
    output logic [AW-1:0] wb_adr_o,
    output logic [DW-1:0] wb_dat_o,
    input  logic [DW-1:0] wb_dat_i,
    input  logic          wb_ack_i
);

    wb_mstate_t state_r;
    wb_rsp_t    rsp_r;
    wb_cmd_t    wdata_s;
    wb_cmd_t    head_s;
    logic       full_s;
    logic       empty_s;
    logic       push_s;
    logic       pop_s;
    logic       timeout_s;

    assign cmd_ready = !full_s;
    assign push_s    = cmd_valid && !full_s;
    assign wdata_s   = '{we: cmd_we, adr: cmd_adr, dat: cmd_dat};
    assign wb_stb_o  = wb_cyc_o;
    assign busy      = (state_r != IDLE) || !empty_s;
    assign rsp_we    = rsp_r.we;
    assign rsp_dat   = rsp_r.dat;
    assign rsp_err   = rsp_r.err;

    wb_cmd_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push_s),
        .wdata (wdata_s),
        .pop   (pop_s),
        .rdata (head_s),
        .full  (full_s),
        .empty (empty_s)
    );

    // Pop the head whenever the FSM is about to launch a new bus cycle.
    always_comb begin
        pop_s = 1'b0;
        case (state_r)
            IDLE:    pop_s = !empty_s;
            RESP:    pop_s = rsp_ready && !empty_s;
            default: pop_s = 1'b0;
        endcase
    end

`ifdef WB_MASTER_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT);
    localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT - 1);
    localparam logic [TW-1:0] T_ONE  = TW'(1);

    logic [TW-1:0] tcnt_r;

    assign timeout_s = (tcnt_r == T_LAST);

    // Counts BUS cycles; held at zero outside BUS so every entry starts fresh.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tcnt_r <= {TW{1'b0}};
        end else if (state_r != BUS) begin
            tcnt_r <= {TW{1'b0}};
        end else if (!timeout_s) begin
            tcnt_r <= tcnt_r + T_ONE;
        end else begin
            tcnt_r <= tcnt_r;
        end
    end
`else
    assign timeout_s = 1'b0;
`endif

    // Main FSM with registered Wishbone outputs and response register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r   <= IDLE;
            wb_cyc_o  <= 1'b0;
            wb_we_o   <= 1'b0;
            wb_adr_o  <= {AW{1'b0}};
            wb_dat_o  <= {DW{1'b0}};
            rsp_valid <= 1'b0;
            rsp_r     <= '{we: 1'b0, dat: {DW{1'b0}}, err: 1'b0};
        end else begin
            case (state_r)
                IDLE: begin
                    if (!empty_s) begin
                        wb_we_o  <= head_s.we;
                        wb_adr_o <= head_s.adr;
                        wb_dat_o <= head_s.dat;
                        wb_cyc_o <= 1'b1;
                        state_r  <= BUS;
                    end
                end
                BUS: begin
                    // ACK takes priority over a timeout on the same edge.
                    if (wb_ack_i) begin
                        wb_cyc_o  <= 1'b0;
                        rsp_r     <= '{we: wb_we_o, dat: (wb_we_o ? {DW{1'b0}} : wb_dat_i), err: 1'b0};
                        rsp_valid <= 1'b1;
                        state_r   <= RESP;
                    end else if (timeout_s) begin
                        wb_cyc_o  <= 1'b0;
                        rsp_r     <= '{we: wb_we_o, dat: {DW{1'b0}}, err: 1'b1};
                        rsp_valid <= 1'b1;
                        state_r   <= RESP;
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        if (!empty_s) begin
                            wb_we_o  <= head_s.we;
                            wb_adr_o <= head_s.adr;
                            wb_dat_o <= head_s.dat;
                            wb_cyc_o <= 1'b1;
                            state_r  <= BUS;
                        end else begin
                            state_r <= IDLE;
                        end
                    end
                end
                default: begin
                    state_r   <= IDLE;
                    wb_cyc_o  <= 1'b0;
                    rsp_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule
